snake_segment_store: RTL and testbench

SNAKE_SEGMENT_STORE -- requirements
Module: snake_segment_store

---
 rtl/snake_pkg.sv | 18 +
 rtl/snake_segment_ram.sv | 55 +++++
 rtl/snake_segment_store.sv | 185 ++++++++++++++++++
 tb/tb_snake_segment_store.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared snake constants and segment-store FSM encoding.
// Also consumed by the game FSM for the spawn cell.
package snake_pkg;

  localparam int DEF_COORD_BITS  = 7;
  localparam int DEF_LENGTH_BITS = 7;
  localparam int DEF_MAX_LENGTH  = 100;
  localparam int DEF_INIT_LENGTH = 3;
  localparam int SNAKE_INIT_X    = 40;
  localparam int SNAKE_INIT_Y    = 30;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } seg_state_t;

endpackage

// File: rtl/snake_segment_ram.sv
// Segment storage: one write port, registered read port, and a
// combinational scan port present only with SNAKE_SEGMENT_COLLISION_EN.
module snake_segment_ram #(
  parameter int CB          = 7,
  parameter int LB          = 7,
  parameter int INIT_LENGTH = 3,
  parameter int INIT_X      = 40,
  parameter int INIT_Y      = 30
) (
  input  logic          clk_i,
  input  logic          init_i,
  input  logic          we_i,
  input  logic [LB-1:0] waddr_i,
  input  logic [2*CB-1:0] wdata_i,
  input  logic [LB-1:0] raddr_i,
  output logic [2*CB-1:0] rdata_o
`ifdef SNAKE_SEGMENT_COLLISION_EN
  ,
  input  logic [LB-1:0] saddr_i,
  output logic [2*CB-1:0] sdata_o
`endif
);

  localparam int DEPTH = 2 ** LB;

  logic [2*CB-1:0] mem_q [DEPTH];
  logic [2*CB-1:0] rdata_q;

  // Spawn body lies left of the head on one row, tail at entry 0.
  function automatic logic [2*CB-1:0] seed(int k);
    if (k < INIT_LENGTH)
      return {CB'(INIT_X - (INIT_LENGTH - 1 - k)), CB'(INIT_Y)};
    return '0;
  endfunction

  always_ff @(posedge clk_i) begin
    if (init_i) begin
      for (int k = 0; k < DEPTH; k++)
        mem_q[k] <= seed(k);
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

`ifdef SNAKE_SEGMENT_COLLISION_EN
  assign sdata_o = mem_q[saddr_i];
`endif

endmodule

// File: rtl/snake_segment_store.sv
// Snake body ring buffer with step/grow commit and read port.
// SNAKE_SEGMENT_COLLISION_EN adds the self-collision scan and hit pulse.
module snake_segment_store
  import snake_pkg::*;
#(
  parameter int COORD_BITS  = DEF_COORD_BITS,
  parameter int LENGTH_BITS = DEF_LENGTH_BITS,
  parameter int MAX_LENGTH  = DEF_MAX_LENGTH,
  parameter int INIT_LENGTH = DEF_INIT_LENGTH,
  parameter int INIT_X      = SNAKE_INIT_X,
  parameter int INIT_Y      = SNAKE_INIT_Y
) (
  input  logic                   clock_25,
  input  logic                   reset,
  input  logic                   sync_reset,
  input  logic                   step,
  input  logic                   grow,
  input  logic [COORD_BITS-1:0]  head_x,
  input  logic [COORD_BITS-1:0]  head_y,
  input  logic [LENGTH_BITS-1:0] rd_index,
  output logic [COORD_BITS-1:0]  rd_x,
  output logic [COORD_BITS-1:0]  rd_y,
  output logic                   rd_valid,
  output logic [LENGTH_BITS-1:0] snake_length,
  output logic                   full,
  output logic                   busy,
  output logic                   hit,
  output logic                   overrun
);

  typedef logic [LENGTH_BITS-1:0] len_t;

  localparam len_t MAX_L  = len_t'(MAX_LENGTH);
  localparam len_t INIT_L = len_t'(INIT_LENGTH);

  seg_state_t            state_q;
  len_t                  head_ptr_q;
  len_t                  len_q;
  logic [COORD_BITS-1:0] lat_x_q;
  logic [COORD_BITS-1:0] lat_y_q;
  logic                  eff_grow_q;
  logic                  busy_q;
  logic                  overrun_q;
  logic                  rd_valid_q;

  logic                    init;
  len_t                    ptr_d;
  len_t                    len_d;
  len_t                    rd_addr;
  logic                    commit_we;
  logic [2*COORD_BITS-1:0] rdata;

  // Segment i sits at (ptr - i) mod MAX_LENGTH.
  function automatic len_t ring_idx(len_t ptr, len_t i);
    logic [LENGTH_BITS:0] s;
    s = {1'b0, ptr} + {1'b0, MAX_L} - {1'b0, i};
    if (s >= {1'b0, MAX_L})
      s = s - {1'b0, MAX_L};
    return s[LENGTH_BITS-1:0];
  endfunction

  assign init    = ~reset | sync_reset;
  assign ptr_d   = (head_ptr_q == MAX_L - len_t'(1))
                 ? '0 : head_ptr_q + len_t'(1);
  assign len_d   = len_q + len_t'(eff_grow_q);
  assign rd_addr = ring_idx(head_ptr_q, rd_index);

`ifdef SNAKE_SEGMENT_COLLISION_EN
  len_t                    scan_q;
  len_t                    scan_last;
  len_t                    scan_addr;
  logic                    hit_q;
  logic                    scan_match;
  logic [2*COORD_BITS-1:0] sdata;

  // A vacating tail cannot be hit, so it is left out of the scan.
  assign scan_last  = eff_grow_q ? len_q - len_t'(1)
                                 : len_q - len_t'(2);
  assign scan_addr  = ring_idx(head_ptr_q, scan_q);
  assign scan_match = (sdata == {lat_x_q, lat_y_q});
  assign commit_we  = (state_q == ST_COMMIT) & ~hit_q;
  assign hit        = hit_q;
`else
  assign commit_we  = (state_q == ST_COMMIT);
  assign hit        = 1'b0;
`endif

  always_ff @(posedge clock_25) begin
    if (init) begin
      state_q    <= ST_IDLE;
      head_ptr_q <= INIT_L - len_t'(1);
      len_q      <= INIT_L;
      lat_x_q    <= '0;
      lat_y_q    <= '0;
      eff_grow_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef SNAKE_SEGMENT_COLLISION_EN
      hit_q      <= 1'b0;
      scan_q     <= '0;
`endif
    end else begin
      if (step && state_q != ST_IDLE)
        overrun_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (step) begin
            lat_x_q    <= head_x;
            lat_y_q    <= head_y;
            eff_grow_q <= grow & ~full;
            busy_q     <= 1'b1;
`ifdef SNAKE_SEGMENT_COLLISION_EN
            scan_q     <= '0;
            state_q    <= ST_SCAN;
`else
            state_q    <= ST_COMMIT;
`endif
          end
        end
`ifdef SNAKE_SEGMENT_COLLISION_EN
        ST_SCAN: begin
          if (scan_match) begin
            hit_q   <= 1'b1;
            state_q <= ST_COMMIT;
          end else if (scan_q == scan_last) begin
            state_q <= ST_COMMIT;
          end else begin
            scan_q  <= scan_q + len_t'(1);
          end
        end
`endif
        ST_COMMIT: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
`ifdef SNAKE_SEGMENT_COLLISION_EN
          hit_q   <= 1'b0;
`endif
          if (commit_we) begin
            head_ptr_q <= ptr_d;
            len_q      <= len_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_25) begin
    if (init)
      rd_valid_q <= 1'b0;
    else
      rd_valid_q <= (rd_index < len_q);
  end

  snake_segment_ram #(
    .CB          (COORD_BITS),
    .LB          (LENGTH_BITS),
    .INIT_LENGTH (INIT_LENGTH),
    .INIT_X      (INIT_X),
    .INIT_Y      (INIT_Y)
  ) u_ram (
    .clk_i   (clock_25),
    .init_i  (init),
    .we_i    (commit_we),
    .waddr_i (ptr_d),
    .wdata_i ({lat_x_q, lat_y_q}),
    .raddr_i (rd_addr),
    .rdata_o (rdata)
`ifdef SNAKE_SEGMENT_COLLISION_EN
    ,
    .saddr_i (scan_addr),
    .sdata_o (sdata)
`endif
  );

  assign rd_x = rd_valid_q ? rdata[2*COORD_BITS-1:COORD_BITS] : '0;
  assign rd_y = rd_valid_q ? rdata[COORD_BITS-1:0] : '0;

  assign rd_valid     = rd_valid_q;
  assign snake_length = len_q;
  assign full         = (len_q == MAX_L);
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_snake_segment_store.sv
// Bench for snake_segment_store with a 6-entry ring.
// Adapts timing/hit expectations to SNAKE_SEGMENT_COLLISION_EN.
module tb_snake_segment_store;

  localparam int CB    = 7;
  localparam int LB    = 7;
  localparam int MAXL  = 6;
  localparam int INITL = 3;
  localparam int IX    = 40;
  localparam int IY    = 30;
`ifdef SNAKE_SEGMENT_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic          clock_25 = 1'b0;
  logic          reset, sync_reset, step, grow;
  logic [CB-1:0] head_x, head_y;
  logic [LB-1:0] rd_index;
  logic [CB-1:0] rd_x, rd_y;
  logic          rd_valid;
  logic [LB-1:0] snake_length;
  logic          full, busy, hit, overrun;

  snake_segment_store #(
    .COORD_BITS  (CB),
    .LENGTH_BITS (LB),
    .MAX_LENGTH  (MAXL),
    .INIT_LENGTH (INITL),
    .INIT_X      (IX),
    .INIT_Y      (IY)
  ) dut (
    .clock_25     (clock_25),
    .reset        (reset),
    .sync_reset   (sync_reset),
    .step         (step),
    .grow         (grow),
    .head_x       (head_x),
    .head_y       (head_y),
    .rd_index     (rd_index),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .rd_valid     (rd_valid),
    .snake_length (snake_length),
    .full         (full),
    .busy         (busy),
    .hit          (hit),
    .overrun      (overrun)
  );

  always #5 clock_25 = ~clock_25;

  typedef struct {int v; int x; int y;} rd_exp_t;
  typedef struct {int hx; int hy; bit g; int len; int full;} vec_t;

  rd_exp_t exp_q[$];
  int      mx[$];
  int      my[$];
  int      errors = 0;
  int      checks = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_25);
    #1;
  endtask

  task automatic model_init();
    mx.delete();
    my.delete();
    for (int i = 0; i < INITL; i++) begin
      mx.push_back(IX - i);
      my.push_back(IY);
    end
  endtask

  task automatic rd_seg(string nm, int idx);
    rd_exp_t e;
    e.v = (idx < mx.size()) ? 1 : 0;
    e.x = e.v ? mx[idx] : 0;
    e.y = e.v ? my[idx] : 0;
    exp_q.push_back(e);
    rd_index = LB'(idx);
    tick();
    e = exp_q.pop_front();
    chk($sformatf("%s_rd_valid[%0d]", nm, idx), int'(rd_valid), e.v);
    chk($sformatf("%s_rd_x[%0d]", nm, idx), int'(rd_x), e.x);
    chk($sformatf("%s_rd_y[%0d]", nm, idx), int'(rd_y), e.y);
  endtask

  task automatic check_all(string nm);
    chk({nm, "_length"}, int'(snake_length), mx.size());
    chk({nm, "_full"}, int'(full), (mx.size() == MAXL) ? 1 : 0);
    for (int i = 0; i <= mx.size(); i++)
      rd_seg(nm, i);
  endtask

  task automatic wait_idle(output int cnt, output int hits);
    cnt = 0;
    hits = 0;
    while (busy && cnt < 100) begin
      cnt++;
      hits += int'(hit);
      tick();
    end
  endtask

  task automatic model_step(int hx, int hy, bit eg, bit hitd);
    if (!hitd) begin
      mx.push_front(hx);
      my.push_front(hy);
      if (!eg) begin
        void'(mx.pop_back());
        void'(my.pop_back());
      end
    end
  endtask

  task automatic do_step(int hx, int hy, bit g, string nm);
    int ci, last, eb, eh, cnt, hits;
    bit eg;
    rd_exp_t e;
    eg   = g && (mx.size() < MAXL);
    last = eg ? mx.size() - 1 : mx.size() - 2;
    ci   = -1;
    for (int i = last; i >= 0; i--)
      if (mx[i] == hx && my[i] == hy) ci = i;
    eh = (COLL && ci >= 0) ? 1 : 0;
    eb = !COLL ? 1 : ((ci >= 0) ? ci + 2 : last + 2);
    e.v = 1;
    e.x = mx[0];
    e.y = my[0];
    exp_q.push_back(e);
    rd_index = '0;
    head_x = CB'(hx);
    head_y = CB'(hy);
    grow = g;
    step = 1'b1;
    tick();
    step = 1'b0;
    grow = 1'b0;
    wait_idle(cnt, hits);
    chk({nm, "_busy_cycles"}, cnt, eb);
    chk({nm, "_hit_pulses"}, hits, eh);
    e = exp_q.pop_front();
    chk({nm, "_commit_rd_x"}, int'(rd_x), e.x);
    chk({nm, "_commit_rd_y"}, int'(rd_y), e.y);
    model_step(hx, hy, eg, eh != 0);
    check_all(nm);
  endtask

  vec_t vt[5];
  int   cnt, hits;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{41, 30, 1'b0, 3, 0};
    vt[1] = '{42, 30, 1'b1, 4, 0};
    vt[2] = '{43, 30, 1'b1, 5, 0};
    vt[3] = '{43, 31, 1'b1, 6, 1};
    vt[4] = '{42, 31, 1'b1, 6, 1};

    reset = 1'b0;
    sync_reset = 1'b0;
    step = 1'b0;
    grow = 1'b0;
    head_x = '0;
    head_y = '0;
    rd_index = '0;
    model_init();
    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_x", int'(rd_x), 0);
    chk("rst_rd_y", int'(rd_y), 0);
    chk("rst_length", int'(snake_length), INITL);
    reset = 1'b1;
    check_all("init");
    rd_seg("far", 100);

    for (int i = 0; i < 5; i++) begin
      do_step(vt[i].hx, vt[i].hy, vt[i].g, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tbl_len", i), int'(snake_length), vt[i].len);
      chk($sformatf("vec%0d_tbl_full", i), int'(full), vt[i].full);
    end

    do_step(42, 30, 1'b0, "curl");
    do_step(mx[mx.size()-1], my[my.size()-1], 1'b0, "tail");
    do_step(mx[mx.size()-1], my[my.size()-1], 1'b1, "tailfull");

    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    model_init();
    check_all("sync");
    do_step(38, 30, 1'b1, "tailgrow");

    head_x = 7'd50;
    head_y = 7'd20;
    grow = 1'b0;
    step = 1'b1;
    tick();
    tick();
    step = 1'b0;
    wait_idle(cnt, hits);
    chk("ovr_idle", int'(busy), 0);
    chk("ovr_flag", int'(overrun), 1);
    model_step(50, 20, 1'b0, 1'b0);
    check_all("ovr");
    chk("ovr_sticky", int'(overrun), 1);

    head_x = 7'd51;
    head_y = 7'd21;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("abort_busy_pre", int'(busy), 1);
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_overrun", int'(overrun), 0);
    chk("abort_hit", int'(hit), 0);
    model_init();
    check_all("abort");

    do_step(41, 31, 1'b1, "pre_rst");
    head_x = 7'd60;
    head_y = 7'd10;
    reset = 1'b0;
    sync_reset = 1'b1;
    step = 1'b1;
    tick();
    reset = 1'b1;
    sync_reset = 1'b0;
    step = 1'b0;
    chk("rstprio_busy", int'(busy), 0);
    chk("rstprio_rd_valid", int'(rd_valid), 0);
    model_init();
    check_all("rstprio");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
